// File: rtl/uart_apb_pkg.sv
// Shared register map, bit positions and TX launch state encoding for the
// APB-to-UART FIFO bridge.
package uart_apb_pkg;

    localparam logic [4:0] ADDR_ENABLE   = 5'h00;
    localparam logic [4:0] ADDR_CTRL     = 5'h04;
    localparam logic [4:0] ADDR_STATUS   = 5'h08;
    localparam logic [4:0] ADDR_DATA     = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h14;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_BUSY  = 4;
    localparam int ST_TX_COUNT = 8;
    localparam int ST_RX_COUNT = 16;

    localparam int IRQ_RX_AVAIL = 0;
    localparam int IRQ_TX_EMPTY = 1;
    localparam int IRQ_RX_OVF   = 2;
    localparam int IRQ_TX_OVF   = 3;
    localparam int IRQ_RX_FRAME = 4;
    localparam int IRQ_RX_PAR   = 5;
    localparam int IRQ_RX_STOP  = 6;
    localparam int IRQ_W        = 7;

    // Only these IRQ_STAT bits are held in flops; the two low bits are live FIFO levels.
    localparam logic [IRQ_W-1:0] IRQ_STICKY_MASK = 7'b111_1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count = r_wptr - r_rptr;
    assign rdata = r_mem[r_rptr[AW-1:0]];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// APB3 register front end for a UART core: TX/RX FIFOs, control registers,
// sticky error flags with a registered level interrupt, and the TX launch FSM.
module apb_uart_fifo_bridge
    import uart_apb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic [2:0]        rx_err,
    output logic [1:0]        parity_type,
    output logic [1:0]        baud_rate,
    output logic              irq,
    output logic [1:0]        dbg_tx_state
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [1:0]        r_enable;
    logic [3:0]        r_ctrl;
    logic [IRQ_W-1:0]  r_irq_en;
    logic [IRQ_W-1:0]  r_irq_sticky;
    logic              r_irq;
    tx_state_e         r_state;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_start;

    logic              w_access, w_wr, w_rd;
    logic [4:0]        w_addr;
    logic              w_addr_ok;
    logic [31:0]       w_rdata;
    logic [31:0]       w_status;
    logic [IRQ_W-1:0]  w_irq_stat, w_irq_set, w_irq_clr;
    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf;
    logic              w_rx_cap, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf, w_rx_udf;
    logic [DATA_W-1:0] w_tx_rdata, w_rx_rdata;
    logic [TX_AW:0]    w_tx_count;
    logic [RX_AW:0]    w_rx_count;
    logic              w_unused_bits;

    assign w_access      = PSEL & PENABLE;
    assign w_wr          = w_access & PWRITE;
    assign w_rd          = w_access & ~PWRITE;
    assign w_addr        = {PADDR[4:2], 2'b00};
    assign w_unused_bits = ^{PADDR[1:0], PWDATA};

    assign w_tx_ovf  = w_wr & (w_addr == ADDR_DATA) & w_tx_full;
    assign w_tx_push = w_wr & (w_addr == ADDR_DATA) & ~w_tx_full;
    assign w_tx_pop  = (r_state == IDLE) & r_enable[1] & ~w_tx_empty;

    // A capture into a full RX FIFO is only lost when no APB pop drains it that cycle.
    assign w_rx_udf  = w_rd & (w_addr == ADDR_DATA) & w_rx_empty;
    assign w_rx_pop  = w_rd & (w_addr == ADDR_DATA) & ~w_rx_empty;
    assign w_rx_cap  = rx_done & r_enable[0];
    assign w_rx_ovf  = w_rx_cap & w_rx_full & ~w_rx_pop;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .wdata (PWDATA[DATA_W-1:0]),
        .rdata (w_tx_rdata),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (w_rx_cap),
        .pop   (w_rx_pop),
        .wdata (rx_data),
        .rdata (w_rx_rdata),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    always_comb begin
        w_status                          = '0;
        w_status[ST_TX_EMPTY]             = w_tx_empty;
        w_status[ST_TX_FULL]              = w_tx_full;
        w_status[ST_RX_EMPTY]             = w_rx_empty;
        w_status[ST_RX_FULL]              = w_rx_full;
        w_status[ST_TX_BUSY]              = (r_state != IDLE);
        w_status[ST_TX_COUNT +: 8]        = 8'(w_tx_count);
        w_status[ST_RX_COUNT +: 8]        = 8'(w_rx_count);

        w_irq_stat                        = r_irq_sticky;
        w_irq_stat[IRQ_RX_AVAIL]          = ~w_rx_empty;
        w_irq_stat[IRQ_TX_EMPTY]          = w_tx_empty;

        // rx_err is ordered {frame, parity, stop}.
        w_irq_set                         = '0;
        w_irq_set[IRQ_RX_OVF]             = w_rx_ovf;
        w_irq_set[IRQ_TX_OVF]             = w_tx_ovf;
        w_irq_set[IRQ_RX_FRAME]           = w_rx_cap & rx_err[2];
        w_irq_set[IRQ_RX_PAR]             = w_rx_cap & rx_err[1];
        w_irq_set[IRQ_RX_STOP]            = w_rx_cap & rx_err[0];

        w_irq_clr = (w_wr && (w_addr == ADDR_IRQ_STAT)) ? PWDATA[IRQ_W-1:0] : '0;
    end

    always_comb begin
        w_rdata   = '0;
        w_addr_ok = 1'b1;
        case (w_addr)
            ADDR_ENABLE:   w_rdata = 32'(r_enable);
            ADDR_CTRL:     w_rdata = 32'(r_ctrl);
            ADDR_STATUS:   w_rdata = w_status;
            ADDR_DATA:     w_rdata = w_rx_empty ? 32'h0 : 32'(w_rx_rdata);
            ADDR_IRQ_EN:   w_rdata = 32'(r_irq_en);
            ADDR_IRQ_STAT: w_rdata = 32'(w_irq_stat);
            default:       w_addr_ok = 1'b0;
        endcase
    end

    assign PREADY  = w_access;
    assign PRDATA  = w_rd ? w_rdata : 32'h0;
    assign PSLVERR = w_access & (~w_addr_ok | w_tx_ovf | w_rx_udf);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_enable     <= '0;
            r_ctrl       <= '0;
            r_irq_en     <= '0;
            r_irq_sticky <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr && (w_addr == ADDR_ENABLE)) r_enable <= PWDATA[1:0];
            if (w_wr && (w_addr == ADDR_CTRL))   r_ctrl   <= PWDATA[3:0];
            if (w_wr && (w_addr == ADDR_IRQ_EN)) r_irq_en <= PWDATA[IRQ_W-1:0];
            r_irq_sticky <= ((r_irq_sticky & ~w_irq_clr) | w_irq_set) & IRQ_STICKY_MASK;
            r_irq        <= |(w_irq_stat & r_irq_en);
        end
    end

    // Clearing tx_en only blocks the next launch from IDLE; a frame in WAIT runs to tx_done.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tx_pop) begin
                        r_state    <= LOAD;
                        r_tx_data  <= w_tx_rdata;
                        r_tx_start <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state    <= WAIT;
                    r_tx_start <= 1'b0;
                end
                WAIT: begin
                    if (tx_done) r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign parity_type  = r_ctrl[1:0];
    assign baud_rate    = r_ctrl[3:2];
    assign irq          = r_irq;
    assign dbg_tx_state = r_state;

endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Directed bench for apb_uart_fifo_bridge: APB register access, TX launch
// ordering, FIFO overflow/underflow, RX capture, interrupts and mid-frame reset.
module tb_apb_uart_fifo_bridge;
    import uart_apb_pkg::*;

    localparam int DATA_W   = 8;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [4:0]        PADDR = '0;
    logic [31:0]       PWDATA = '0;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_done = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_done = 1'b0;
    logic [2:0]        rx_err = '0;
    logic [1:0]        parity_type;
    logic [1:0]        baud_rate;
    logic              irq;
    logic [1:0]        dbg_tx_state;

    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    logic [7:0]        tx_log[$];
    int                start_cyc[$];

    apb_uart_fifo_bridge #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_err       (rx_err),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .irq          (irq),
        .dbg_tx_state (dbg_tx_state)
    );

    // ---------------- clock / reset-time helpers ----------------
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Log every cycle tx_start is high, with the cycle it was seen in.
    initial begin
        forever begin
            @(negedge PCLK);
            if (tx_start === 1'b1) begin
                tx_log.push_back(tx_data);
                start_cyc.push_back(cyc);
            end
        end
    end

    // UART transmitter model: tx_done pulses 10 cycles after each start.
    initial begin
        forever begin
            @(negedge PCLK);
            if (tx_start === 1'b1) begin
                repeat (10) @(negedge PCLK);
                tx_done = 1'b1;
                @(negedge PCLK);
                tx_done = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered 1ns after a rising edge; returns 1ns after the edge that ends the access.
    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output logic rdy);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        #3;
        rdata = PRDATA;
        err   = PSLVERR;
        rdy   = PREADY;
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] addr, input logic [31:0] wdata, output logic err);
        logic [31:0] rd;
        logic        rdy;
        apb_xfer(1'b1, addr, wdata, rd, err, rdy);
    endtask

    task automatic apb_read(input logic [4:0] addr, output logic [31:0] rdata, output logic err);
        logic rdy;
        apb_xfer(1'b0, addr, 32'h0, rdata, err, rdy);
    endtask

    task automatic rx_pulse(input logic [7:0] data, input logic [2:0] err);
        rx_data = data;
        rx_err  = err;
        rx_done = 1'b1;
        @(posedge PCLK);
        #1;
        rx_done = 1'b0;
        rx_err  = 3'b000;
        @(posedge PCLK);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        n_checks++;
        if ({tx_start, tx_data, parity_type, baud_rate, irq} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", {tx_start, tx_data, parity_type, baud_rate, irq});
        end
        n_checks++;
        if (dbg_tx_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_tx_state, IDLE);
        end
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if ({err, rd} !== {1'b0, 32'h0000_0005}) begin
            n_errors++;
            $display("FAIL reset_status: got err=%b data=%h expected err=0 data=00000005", err, rd);
        end
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_errors++;
            $display("FAIL reset_irq_stat: got %h expected 00000002", rd);
        end
        apb_write(ADDR_CTRL, 32'h0000_000B, err);
        apb_read(ADDR_CTRL, rd, err);
        n_checks++;
        if (rd !== 32'h0000_000B || {parity_type, baud_rate} !== 4'b1110) begin
            n_errors++;
            $display("FAIL ctrl_rw: got ctrl=%h parity=%0d baud=%0d expected ctrl=0000000b parity=3 baud=2",
                     rd, parity_type, baud_rate);
        end
    endtask

    task automatic test_tx_launch();
        logic [31:0] rd;
        logic        err;
        int          end_cyc;
        int          k;
        tx_log.delete();
        start_cyc.delete();
        apb_write(ADDR_ENABLE, 32'h2, err);
        apb_write(ADDR_DATA, 32'h41, err);
        end_cyc = cyc;
        apb_write(ADDR_DATA, 32'h42, err);
        apb_write(ADDR_DATA, 32'h43, err);
        k = 0;
        while (!(tx_log.size() == 3 && dbg_tx_state == IDLE) && k < 200) begin
            @(posedge PCLK);
            #1;
            k++;
        end
        n_checks++;
        if (tx_log.size() !== 3) begin
            n_errors++;
            $display("FAIL tx_start_count: got %0d expected 3", tx_log.size());
        end else begin
            n_checks++;
            if ({tx_log[0], tx_log[1], tx_log[2]} !== 24'h414243) begin
                n_errors++;
                $display("FAIL tx_order: got %h expected 414243", {tx_log[0], tx_log[1], tx_log[2]});
            end
            n_checks++;
            if (start_cyc[0] !== end_cyc + 1) begin
                n_errors++;
                $display("FAIL tx_latency: got start cycle %0d expected %0d", start_cyc[0], end_cyc + 1);
            end
        end
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0005 || tx_data !== 8'h43) begin
            n_errors++;
            $display("FAIL tx_drained: got status=%h tx_data=%h expected status=00000005 tx_data=43", rd, tx_data);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] rd;
        logic        err;
        int          bad;
        int          k;
        apb_write(ADDR_ENABLE, 32'h0, err);
        bad = 0;
        for (int i = 0; i < TX_DEPTH; i++) begin
            apb_write(ADDR_DATA, 32'(8'h10 + i), err);
            if (err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL tx_fill_err: got %0d errored writes expected 0", bad);
        end
        apb_write(ADDR_DATA, 32'h18, err);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL tx_ovf_pslverr: got %b expected 1", err);
        end
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0008) begin
            n_errors++;
            $display("FAIL tx_ovf_irq_stat: got %h expected 00000008", rd);
        end
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0806) begin
            n_errors++;
            $display("FAIL tx_full_status: got %h expected 00000806", rd);
        end
        apb_write(ADDR_IRQ_STAT, 32'h08, err);
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0000) begin
            n_errors++;
            $display("FAIL tx_ovf_w1c: got %h expected 00000000", rd);
        end
        tx_log.delete();
        start_cyc.delete();
        apb_write(ADDR_ENABLE, 32'h2, err);
        k = 0;
        while (!(tx_log.size() == TX_DEPTH && dbg_tx_state == IDLE) && k < 400) begin
            @(posedge PCLK);
            #1;
            k++;
        end
        bad = 0;
        for (int i = 0; i < tx_log.size(); i++) begin
            if (tx_log[i] !== 8'(8'h10 + i)) bad++;
        end
        n_checks++;
        if (tx_log.size() !== TX_DEPTH || bad !== 0) begin
            n_errors++;
            $display("FAIL tx_drain_order: got %0d bytes with %0d wrong expected 8 bytes 10..17",
                     tx_log.size(), bad);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] rd;
        logic        err;
        int          bad;
        apb_write(ADDR_ENABLE, 32'h1, err);
        for (int i = 0; i <= RX_DEPTH; i++) rx_pulse(8'(i), 3'b000);
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0008_0009) begin
            n_errors++;
            $display("FAIL rx_full_status: got %h expected 00080009", rd);
        end
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0007) begin
            n_errors++;
            $display("FAIL rx_ovf_irq_stat: got %h expected 00000007", rd);
        end
        bad = 0;
        for (int i = 0; i < RX_DEPTH; i++) begin
            apb_read(ADDR_DATA, rd, err);
            if (rd !== 32'(i) || err !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL rx_read_order: got %0d wrong reads expected 0", bad);
        end
        apb_read(ADDR_DATA, rd, err);
        n_checks++;
        if ({err, rd} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL rx_underflow: got err=%b data=%h expected err=1 data=00000000", err, rd);
        end
        apb_write(ADDR_IRQ_STAT, 32'h04, err);
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_errors++;
            $display("FAIL rx_ovf_w1c: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_rx_simultaneous();
        logic [31:0] rd;
        logic        err;
        int          bad;
        for (int i = 0; i < RX_DEPTH; i++) rx_pulse(8'(8'h30 + i), 3'b000);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = ADDR_DATA;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        rx_data = 8'h38;
        rx_done = 1'b1;
        #3;
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        rx_done = 1'b0;
        n_checks++;
        if ({err, rd} !== {1'b0, 32'h30}) begin
            n_errors++;
            $display("FAIL rx_simul_read: got err=%b data=%h expected err=0 data=00000030", err, rd);
        end
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0008_0009) begin
            n_errors++;
            $display("FAIL rx_simul_status: got %h expected 00080009", rd);
        end
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0003) begin
            n_errors++;
            $display("FAIL rx_simul_no_ovf: got %h expected 00000003", rd);
        end
        bad = 0;
        for (int i = 1; i <= RX_DEPTH; i++) begin
            apb_read(ADDR_DATA, rd, err);
            if (rd !== 32'(8'h30 + i)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL rx_simul_drain: got %0d wrong reads expected 0", bad);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        err;
        apb_write(ADDR_IRQ_EN, 32'h20, err);
        rx_data = 8'h55;
        rx_err  = 3'b010;
        rx_done = 1'b1;
        @(posedge PCLK);
        #1;
        rx_done = 1'b0;
        rx_err  = 3'b000;
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_early: got %b expected 0", irq);
        end
        @(posedge PCLK);
        #1;
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        apb_read(ADDR_IRQ_STAT, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0023) begin
            n_errors++;
            $display("FAIL irq_stat_parity: got %h expected 00000023", rd);
        end
        apb_write(ADDR_IRQ_STAT, 32'h20, err);
        @(posedge PCLK);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_clear: got %b expected 0", irq);
        end
        apb_read(ADDR_DATA, rd, err);
        n_checks++;
        if (rd !== 32'h55) begin
            n_errors++;
            $display("FAIL irq_rx_byte: got %h expected 00000055", rd);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        logic        err;
        logic        rdy;
        apb_xfer(1'b0, 5'h18, 32'h0, rd, err, rdy);
        n_checks++;
        if ({rdy, err, rd} !== {1'b1, 1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL bad_addr_read: got ready=%b err=%b data=%h expected ready=1 err=1 data=00000000",
                     rdy, err, rd);
        end
        apb_write(5'h1C, 32'hFFFF_FFFF, err);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL bad_addr_write: got err=%b expected 1", err);
        end
        apb_xfer(1'b0, ADDR_ENABLE, 32'h0, rd, err, rdy);
        n_checks++;
        if ({rdy, err, rd} !== {1'b1, 1'b0, 32'h1}) begin
            n_errors++;
            $display("FAIL enable_intact: got ready=%b err=%b data=%h expected ready=1 err=0 data=00000001",
                     rdy, err, rd);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic        err;
        int          k;
        int          n_starts;
        apb_write(ADDR_ENABLE, 32'h2, err);
        apb_write(ADDR_DATA, 32'hA1, err);
        apb_write(ADDR_DATA, 32'hA2, err);
        apb_write(ADDR_DATA, 32'hA3, err);
        k = 0;
        while (dbg_tx_state != WAIT && k < 20) begin
            @(posedge PCLK);
            #1;
            k++;
        end
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0214 || dbg_tx_state !== WAIT) begin
            n_errors++;
            $display("FAIL pre_reset_wait: got status=%h state=%0d expected status=00000214 state=%0d",
                     rd, dbg_tx_state, WAIT);
        end
        n_starts = tx_log.size();
        PRESETn = 1'b0;
        #2;
        n_checks++;
        if ({tx_start, tx_data, parity_type, baud_rate, irq, dbg_tx_state} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0",
                     {tx_start, tx_data, parity_type, baud_rate, irq, dbg_tx_state});
        end
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (20) @(posedge PCLK);
        #1;
        apb_read(ADDR_STATUS, rd, err);
        n_checks++;
        if (rd !== 32'h0000_0005 || tx_log.size() !== n_starts || dbg_tx_state !== IDLE) begin
            n_errors++;
            $display("FAIL post_reset: got status=%h starts=%0d state=%0d expected status=00000005 starts=%0d state=%0d",
                     rd, tx_log.size(), dbg_tx_state, n_starts, IDLE);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tx_launch();
        test_tx_overflow();
        test_rx_overflow();
        test_rx_simultaneous();
        test_irq();
        test_bad_addr();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_fifo_bridge.md
# apb_uart_fifo_bridge

APB3 slave that connects the system APB bus to a UART TX/RX core through parametrised TX and RX FIFOs. It decodes a register map covering enable, control, status, data and interrupts, and runs a TX launch state machine that drains the TX FIFO into the UART transmitter. RX bytes are buffered automatically. Sticky error and overflow flags drive a level interrupt. This block sits between the APB interconnect and the UART TX/RX core, and supersedes the earlier single-register UART bridge.

## Interface
- DATA_W, 8: UART character width; 5..9 are legal.
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥2.
- PCLK  in  1  sole clock; all state updates on the rising edge.
- PRESETn  in  1  reset; asynchronous assert, active-low (already decided).
- PSEL, PENABLE, PWRITE  in  1  APB control.
- PADDR  in  5  byte address; PADDR[1:0] is ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tx_data  out  DATA_W  byte presented to the UART transmitter.
- tx_start  out  1  one-cycle launch pulse.
- tx_done  in  1  one-cycle pulse at the end of a frame.
- rx_data  in  DATA_W  received byte.
- rx_done  in  1  one-cycle pulse when rx_data is valid.
- rx_err  in  3  {frame, parity, stop} error, sampled on rx_done.
- parity_type  out  2  parity select to the UART core.
- baud_rate  out  2  baud select to the UART core.
- irq  out  1  level interrupt, equal to |(IRQ_STAT & IRQ_EN).

## Operation
- Register map:
  - 0x00 ENABLE (RW): bit0 rx_en, bit1 tx_en.
  - 0x04 CTRL (RW): [1:0] parity_type, [3:2] baud_rate.
  - 0x08 STATUS (RO): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_busy, [15:8] tx_count, [23:16] rx_count.
  - 0x0C DATA:
    - Write pushes PWDATA[DATA_W-1:0] into the TX FIFO.
    - Read pops the RX FIFO and returns the byte zero-extended.
  - 0x10 IRQ_EN (RW).
  - 0x14 IRQ_STAT (write-1-to-clear). Bits: [0] rx_avail (level, not clearable), [1] tx_empty (level), [2] rx_ovf, [3] tx_ovf, [4] rx_frame, [5] rx_parity, [6] rx_stop.
- Any other address: PSLVERR=1, writes are ignored, PRDATA=0.
- Writing DATA while the TX FIFO is full:
  - The byte is dropped, PSLVERR=1, tx_ovf is set.
- Reading DATA while the RX FIFO is empty:
  - PRDATA=0, PSLVERR=1, FIFO state is unchanged.
- RX capture on rx_done with rx_en=1:
  - Push rx_data and OR rx_err into IRQ_STAT[6:4].
  - If the RX FIFO is full, drop the byte and set rx_ovf.
  - rx_done while rx_en=0 is ignored entirely.
- Simultaneous rx_done push and APB DATA pop: both take effect in the same cycle.
  - On a full FIFO this is not an overflow; count stays unchanged.
- TX launch FSM:
  - IDLE → LOAD when tx_en=1 and the TX FIFO is not empty. The FIFO is popped into the tx_data register.
  - LOAD: assert tx_start for one cycle, then go to WAIT.
  - WAIT → IDLE on tx_done.
  - tx_busy = (state ≠ IDLE).
- Clearing tx_en mid-frame: the current frame completes; no further launch happens; FIFO contents are kept.
- A same-cycle APB push and FSM pop are both honoured.

## Timing
- APB: zero wait states. PREADY=1 whenever PSEL&PENABLE, otherwise 0.
- PRDATA and PSLVERR are combinational during the access phase and 0 otherwise.
- All register updates, FIFO pushes and pops take effect on the PCLK edge that ends the access phase.
- TX latency: the DATA write ends at edge N.
  - LOAD is entered at N+1.
  - tx_start is high in cycle N+1..N+2.
  - tx_data is stable from N+1 until the next LOAD.
- The RX byte is readable in the cycle after the rx_done edge. STATUS updates in the same cycle.
- irq updates one cycle after its source event. It is registered.
- Reset values:
  - All registers, FIFO pointers and counters = 0; FSM = IDLE.
  - tx_start = 0, tx_data = 0, parity_type = 0, baud_rate = 0, irq = 0.
- Reset asserted mid-frame: the FSM returns to IDLE immediately and FIFOs are emptied. A tx_done arriving after reset release is ignored while IDLE.

## Structure
- Package uart_apb_pkg holds:
  - Address constants ADDR_ENABLE..ADDR_IRQ_STAT.
  - STATUS and IRQ bit indices.
  - The tx_state_e enum {IDLE, LOAD, WAIT}.
- Sub-module sync_fifo (params WIDTH, DEPTH), instanced twice.
  - Ports: push, pop, wdata, rdata (show-ahead), full, empty, count.
  - Pointers are log2(DEPTH)+1 bits with wrap-bit full/empty detection.

## Test plan
- Reset, then write ENABLE=0x2 and three DATA writes 0x41, 0x42, 0x43, with tx_done returned 10 cycles after each start. Required: three tx_start pulses with tx_data 0x41, 0x42, 0x43 in order, then STATUS.tx_empty=1.
- tx_en=0, then TX_DEPTH+1 DATA writes. Required: the last write gets PSLVERR=1, IRQ_STAT[3]=1, and tx_count=TX_DEPTH.
- rx_en=1, then RX_DEPTH+1 rx_done pulses carrying 0x00..0x08. Required:
  - rx_ovf=1.
  - Reads return 0x00..0x07.
  - A ninth read returns 0 with PSLVERR=1.
- rx_done with rx_err=3'b010 and IRQ_EN=0x20. Required: irq=1 one cycle later; writing IRQ_STAT=0x20 clears irq.
- Read from address 0x18. Required: PRDATA=0, PSLVERR=1, PREADY=1.
- PRESETn pulsed low during WAIT with 2 bytes queued. Required: all outputs are 0 and FSM=IDLE; after release, tx_count=0 and no tx_start.
